// File: rtl/rcv_pkg.sv
// Shared types and defaults for the serial receive control unit.
// The payload width default is shared with the receiver's shift register.
package rcv_pkg;

  localparam int RCV_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    RECV = 3'd2,
    CHK  = 3'd3,
    EVAL = 3'd4,
    LOAD = 3'd5
  } rcv_state_t;

endpackage

// File: rtl/rcv_ctrl.sv
// Receive control unit: sequences one packet from start-bit detect to buffer load
// and owns the host-facing receive buffer with its data_ready/overrun/framing flags.
module rcv_ctrl
  import rcv_pkg::*;
#(
  parameter int DATA_BITS = RCV_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start_bit_detected,
  input  logic                 packet_done,
  input  logic                 stop_bit,
  input  logic [DATA_BITS-1:0] rx_packet_data,
  input  logic                 data_read,
  output logic                 enable_timer,
  output logic                 sbc_clear,
  output logic                 sbc_enable,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
  output logic                 framing_error,
  output rcv_state_t           dbg_state
);

  // Host handshake: data_ready high means rx_data holds an unread packet; a
  // one-cycle data_read pulse consumes it at the next edge. A load in the same
  // cycle as data_read counts as a fresh packet, not an overrun.

  rcv_state_t             r_state;
  rcv_state_t             w_next;
  logic [DATA_BITS-1:0]   r_rx_data;
  logic                   r_data_ready;
  logic                   r_overrun;
  logic                   r_framing;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start_bit_detected) w_next = CLR;
      CLR:     w_next = RECV;
      RECV:    if (packet_done) w_next = CHK;
      CHK:     w_next = EVAL;
      EVAL:    w_next = stop_bit ? LOAD : IDLE;
      LOAD:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Buffer and sticky flags; framing is cleared as each new packet begins.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rx_data    <= '0;
      r_data_ready <= 1'b0;
      r_overrun    <= 1'b0;
      r_framing    <= 1'b0;
    end else begin
      if (r_state == CLR) begin
        r_framing <= 1'b0;
      end else if (r_state == EVAL && !stop_bit) begin
        r_framing <= 1'b1;
      end

      if (r_state == LOAD) begin
        r_rx_data    <= rx_packet_data;
        r_data_ready <= 1'b1;
        if (data_read) begin
          r_overrun <= 1'b0;
        end else if (r_data_ready) begin
          r_overrun <= 1'b1;
        end
      end else if (data_read) begin
        r_data_ready <= 1'b0;
        r_overrun    <= 1'b0;
      end
    end
  end

  assign enable_timer  = (r_state == RECV);
  assign sbc_clear     = (r_state == CLR);
  assign sbc_enable    = (r_state == CHK);
  assign rx_data       = r_rx_data;
  assign data_ready    = r_data_ready;
  assign overrun_error = r_overrun;
  assign framing_error = r_framing;
  assign dbg_state     = r_state;

endmodule
